trigger_wheel_gen: RTL



---
 rtl/trigger_wheel_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/trigger_wheel_gen.sv
// trigger_wheel_gen
//   Crank/cam trigger-pattern generator. Emits an N-minus-M crank tooth train
//   with a runtime-programmable tooth period and a cam pulse once per 720 deg.
//
// Parameters
//   TEETH     : tooth positions per crank revolution (including missing), >= 3
//   MISSING   : missing teeth, occupying slots TEETH-MISSING .. TEETH-1
//   PERIOD_W  : width of tooth_period
//   CAM_TOOTH : slot in which cam_out is high on cam-phase-0 revolutions
//   IDX_W     : width of tooth_idx
//
// Ports
//   clk          : EFI clock, rising edge
//   reset_n      : synchronous reset, active low
//   enable       : run when 1, idle when 0
//   tooth_period : clk cycles per tooth slot (values below 2 act as 2)
//   crank_out    : high for the first floor(P/2) cycles of each present slot
//   cam_out      : high for the whole CAM_TOOTH slot every second revolution
//   tooth_idx    : current tooth slot
//   rev_strobe   : one-cycle pulse on the first cycle after a revolution wrap
module trigger_wheel_gen #(
    parameter int TEETH     = 36,
    parameter int MISSING   = 1,
    parameter int PERIOD_W  = 16,
    parameter int CAM_TOOTH = 0,
    parameter int IDX_W     = $clog2(TEETH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] tooth_period,
    output logic                crank_out,
    output logic                cam_out,
    output logic [IDX_W-1:0]    tooth_idx,
    output logic                rev_strobe
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // One extra bit so TEETH-MISSING still fits when MISSING = 0.
    localparam logic [IDX_W:0]   PRESENT  = (IDX_W+1)'(TEETH - MISSING);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(TEETH - 1);
    localparam logic [IDX_W-1:0] CAM_SLOT = IDX_W'(CAM_TOOTH);
    localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(2);

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] cnt, cnt_nxt;
    logic [PERIOD_W-1:0] p_lat, p_lat_nxt;
    logic [PERIOD_W-1:0] p_eff;
    logic [IDX_W-1:0]    tooth, tooth_nxt;
    logic                cam_ph, cam_ph_nxt;
    logic                wrap, wrap_nxt;
    logic                running;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            p_lat  <= '0;
            tooth  <= '0;
            cam_ph <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            p_lat  <= p_lat_nxt;
            tooth  <= tooth_nxt;
            cam_ph <= cam_ph_nxt;
            wrap   <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        p_lat_nxt  = p_lat;
        tooth_nxt  = tooth;
        cam_ph_nxt = cam_ph;
        wrap_nxt   = 1'b0;
        p_eff      = (tooth_period < P_MIN) ? P_MIN : tooth_period;

        case (state)
            ST_IDLE: begin
                cnt_nxt    = '0;
                tooth_nxt  = '0;
                cam_ph_nxt = 1'b0;
                if (enable) begin
                    state_nxt = ST_RUN;
                    p_lat_nxt = p_eff;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = '0;
                    p_lat_nxt  = '0;
                    tooth_nxt  = '0;
                    cam_ph_nxt = 1'b0;
                end else if (cnt < p_lat - PERIOD_W'(1)) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    // Period is only resampled at slot boundaries so a
                    // slot never changes length part-way through.
                    cnt_nxt   = '0;
                    p_lat_nxt = p_eff;
                    if (tooth == LAST) begin
                        tooth_nxt  = '0;
                        cam_ph_nxt = ~cam_ph;
                        wrap_nxt   = 1'b1;
                    end else begin
                        tooth_nxt = tooth + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only; no input reaches them directly.
    assign running    = (state == ST_RUN);
    assign crank_out  = running && ({1'b0, tooth} < PRESENT) && (cnt < (p_lat >> 1));
    assign cam_out    = running && (tooth == CAM_SLOT) && !cam_ph;
    assign tooth_idx  = tooth;
    assign rev_strobe = wrap;

endmodule
